// File: rtl/fifo_to_reg_ctrl_pkg.sv
// Shared definitions for the FIFO-to-register frame loader: FSM encoding,
// default geometry and the byte-counter width helper.
package fifo_to_reg_ctrl_pkg;

    localparam int POS_ARRAY_DEF   = 8;
    localparam int FRAME_BYTES_DEF = 10;
    localparam int BYTE_OUT_DEF    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE,
        ST_DISCARD,
        ST_DONE
    } state_e;

    // Counter must be able to hold FRAME_BYTES itself (the terminal count).
    function automatic int cnt_width(input int frame_bytes);
        return $clog2(frame_bytes + 1);
    endfunction

endpackage

// File: rtl/fifo_to_reg_ctrl_xor_chk.sv
// Frame checksum accumulator: XORs the captured payload bytes and flags a
// mismatch against the trailer byte. Only built when FRAME_CHKSUM_EN is defined.
module frame_xor_chk
    import fifo_to_reg_ctrl_pkg::*;
#(
    parameter int BYTE_OUT = BYTE_OUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                cap_i,
    input  logic                cmp_i,
    input  logic [BYTE_OUT-1:0] data_i,
    output logic                mismatch_o
);

    logic [BYTE_OUT-1:0] acc_q;
    logic                mis_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            mis_q <= 1'b0;
        end else if (clr_i) begin
            acc_q <= '0;
            mis_q <= 1'b0;
        end else begin
            if (cap_i) acc_q <= acc_q ^ data_i;
            if (cmp_i) mis_q <= (data_i != acc_q);
        end
    end

    assign mismatch_o = mis_q;

endmodule

// File: rtl/fifo_to_reg_ctrl.sv
// Reads fixed-length frames from a byte FIFO and strobes the first POS_ARRAY
// bytes into per-position registers. Optional checksum via FRAME_CHKSUM_EN.
module fifo_to_reg_ctrl
    import fifo_to_reg_ctrl_pkg::*;
#(
    parameter int POS_ARRAY   = POS_ARRAY_DEF,
    parameter int FRAME_BYTES = FRAME_BYTES_DEF,
    parameter int BYTE_OUT    = BYTE_OUT_DEF
) (
    input  logic                 clk,
    input  logic                 sys_rst_l,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [BYTE_OUT-1:0]  fifo_dout,
    output logic [BYTE_OUT-1:0]  byte_data,
    output logic [POS_ARRAY-1:0] load_en,
    output logic                 frame_valid,
    input  logic                 frame_ack,
    output logic                 frame_err
);

    localparam int CW = cnt_width(FRAME_BYTES);
    typedef logic [CW-1:0] cnt_t;

    state_e               state_q, state_d;
    cnt_t                 cnt_q, cnt_d;
    logic                 rd_q, rd_d;
    logic [BYTE_OUT-1:0]  byte_q, byte_d;
    logic [POS_ARRAY-1:0] load_q, load_d;
    cnt_t                 cnt_inc;

    assign cnt_inc = cnt_q + cnt_t'(1);

    // READ doubles as the starved-wait state: rd_q low means no read is in
    // flight yet, so keep polling fifo_empty with the position held.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = 1'b0;
        byte_d  = byte_q;
        load_d  = '0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    rd_d    = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (rd_q)
                    state_d = (cnt_q < cnt_t'(POS_ARRAY)) ? ST_CAPTURE : ST_DISCARD;
                else if (!fifo_empty)
                    rd_d = 1'b1;
            end
            ST_CAPTURE, ST_DISCARD: begin
                cnt_d = cnt_inc;
                if (state_q == ST_CAPTURE) begin
                    byte_d = fifo_dout;
                    for (int i = 0; i < POS_ARRAY; i++)
                        load_d[i] = (cnt_q == cnt_t'(i));
                end
                if (cnt_inc == cnt_t'(FRAME_BYTES)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_READ;
                    rd_d    = !fifo_empty;
                end
            end
            ST_DONE: begin
                if (frame_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge sys_rst_l) begin
        if (sys_rst_l) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            byte_q  <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            byte_q  <= byte_d;
            load_q  <= load_d;
        end
    end

    assign fifo_rd_en  = rd_q;
    assign byte_data   = byte_q;
    assign load_en     = load_q;
    assign frame_valid = (state_q == ST_DONE);

`ifdef FRAME_CHKSUM_EN
    logic chk_mismatch;

    // Only the first trailer byte carries the checksum.
    frame_xor_chk #(.BYTE_OUT(BYTE_OUT)) u_chk (
        .clk        (clk),
        .rst        (sys_rst_l),
        .clr_i      (state_q == ST_IDLE),
        .cap_i      (state_q == ST_CAPTURE),
        .cmp_i      ((state_q == ST_DISCARD) && (cnt_q == cnt_t'(POS_ARRAY))),
        .data_i     (fifo_dout),
        .mismatch_o (chk_mismatch)
    );

    assign frame_err = frame_valid & chk_mismatch;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_to_reg_ctrl.sv
// Bench for fifo_to_reg_ctrl: FIFO model plus a frame-level reference model,
// directed and random frames, and a second instance with POS_ARRAY == FRAME_BYTES.
module tb_fifo_to_reg_ctrl;

    localparam int P  = 8;
    localparam int F  = 10;
    localparam int P2 = 4;
    localparam int F2 = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fifo_empty = 1'b1, fifo_rd_en, frame_valid, frame_ack = 1'b0, frame_err;
    logic [7:0]    fifo_dout = 8'h00, byte_data;
    logic [P-1:0]  load_en;
    logic          fifo_empty2 = 1'b1, fifo_rd_en2, frame_valid2, frame_ack2 = 1'b1, frame_err2;
    logic [7:0]    fifo_dout2 = 8'h00, byte_data2;
    logic [P2-1:0] load_en2;

    fifo_to_reg_ctrl #(.POS_ARRAY(P), .FRAME_BYTES(F), .BYTE_OUT(8)) dut (
        .clk(clk), .sys_rst_l(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .byte_data(byte_data), .load_en(load_en),
        .frame_valid(frame_valid), .frame_ack(frame_ack), .frame_err(frame_err));

    fifo_to_reg_ctrl #(.POS_ARRAY(P2), .FRAME_BYTES(F2), .BYTE_OUT(8)) dut2 (
        .clk(clk), .sys_rst_l(rst), .fifo_empty(fifo_empty2), .fifo_rd_en(fifo_rd_en2),
        .fifo_dout(fifo_dout2), .byte_data(byte_data2), .load_en(load_en2),
        .frame_valid(frame_valid2), .frame_ack(frame_ack2), .frame_err(frame_err2));

    always #5 clk = ~clk;

    typedef struct { int pos; logic [7:0] b; } ld_t;

    int         nchk = 0, nerr = 0;
    logic [7:0] q[$], q2[$];
    ld_t        expq[$], expq2[$];
    logic       errq[$];
    int         mpos = 0, mpos2 = 0, fpend = 0;
    logic [7:0] mx = 8'h00, last_b = 8'h00, last_b2 = 8'h00, pend = 8'h00, pend2 = 8'h00;
    logic       merr = 1'b0, pend_v = 1'b0, pend2_v = 1'b0, emp_e, emp2_e;
    int         rd_cnt = 0, fv_cnt = 0, rd2_cnt = 0, ld2_cnt = 0, fv2_cnt = 0, ld2_at_valid = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic push2(input logic [7:0] b);
        q2.push_back(b);
        fifo_empty2 = 1'b0;
    endtask

    // One clock: bookkeeping for the coming edge, then checks at the negedge.
    task automatic tick();
        logic [7:0] b;
        ld_t        e;
        if (frame_valid && frame_ack && fpend > 0) begin
            fpend--;
            if (errq.size() > 0) errq.delete(0);
        end
        emp_e  = fifo_empty;
        emp2_e = fifo_empty2;
        @(negedge clk);

        if (load_en !== '0) begin
            if (expq.size() == 0) check("load_unexpected", 32'(load_en), 0);
            else begin
                e = expq.pop_front();
                check("load_en", 32'(load_en), 32'(1) << e.pos);
                check("byte_data", 32'(byte_data), 32'(e.b));
                last_b = e.b;
            end
        end else check("byte_hold", 32'(byte_data), 32'(last_b));

        if (frame_valid) begin
            fv_cnt++;
            check("valid_with_frame", 32'(fpend > 0), 1);
            check("rd_in_done", 32'(fifo_rd_en), 0);
`ifdef FRAME_CHKSUM_EN
            check("frame_err", 32'(frame_err), 32'((errq.size() > 0) ? errq[0] : 1'b0));
`else
            check("frame_err", 32'(frame_err), 0);
`endif
        end else check("err_idle", 32'(frame_err), 0);

        if (pend_v) begin fifo_dout = pend; pend_v = 1'b0; end
        if (fifo_rd_en) begin
            rd_cnt++;
            check("rd_while_empty", 32'(emp_e), 0);
            if (q.size() > 0) begin
                b = q.pop_front();
                pend = b; pend_v = 1'b1;
                fifo_dout = 8'($urandom);
                if (mpos < P) begin
                    expq.push_back('{mpos, b});
                    mx ^= b;
                end else if (mpos == P) merr = (b != mx);
                mpos++;
                if (mpos == F) begin
                    fpend++; errq.push_back(merr);
                    mpos = 0; mx = 8'h00; merr = 1'b0;
                end
            end
        end
        fifo_empty = (q.size() == 0);

        if (load_en2 !== '0) begin
            ld2_cnt++;
            if (expq2.size() == 0) check("load2_unexpected", 32'(load_en2), 0);
            else begin
                e = expq2.pop_front();
                check("load_en2", 32'(load_en2), 32'(1) << e.pos);
                check("byte_data2", 32'(byte_data2), 32'(e.b));
                last_b2 = e.b;
            end
        end else check("byte_hold2", 32'(byte_data2), 32'(last_b2));
        if (frame_valid2) begin
            fv2_cnt++;
            if (ld2_at_valid < 0) ld2_at_valid = ld2_cnt;
            check("rd2_in_done", 32'(fifo_rd_en2), 0);
        end
        check("err2", 32'(frame_err2), 0);
        if (pend2_v) begin fifo_dout2 = pend2; pend2_v = 1'b0; end
        if (fifo_rd_en2) begin
            rd2_cnt++;
            check("rd2_while_empty", 32'(emp2_e), 0);
            if (q2.size() > 0) begin
                b = q2.pop_front();
                pend2 = b; pend2_v = 1'b1;
                fifo_dout2 = 8'($urandom);
                expq2.push_back('{mpos2, b});
                mpos2 = (mpos2 + 1) % F2;
            end
        end
        fifo_empty2 = (q2.size() == 0);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!frame_valid && n < budget) begin tick(); n++; end
        check(tag, 32'(frame_valid), 1);
    endtask

    // Raise reset, check outputs drop at once, and flush FIFOs and models.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_rd_en", 32'(fifo_rd_en), 0);
        check("rst_load_en", 32'(load_en), 0);
        check("rst_byte_data", 32'(byte_data), 0);
        check("rst_valid", 32'(frame_valid), 0);
        check("rst_err", 32'(frame_err), 0);
        check("rst2_outputs", {fifo_rd_en2, frame_valid2, frame_err2, load_en2, byte_data2}, 0);
        q.delete(); expq.delete(); errq.delete(); q2.delete(); expq2.delete();
        mpos = 0; mx = 8'h00; merr = 1'b0; fpend = 0; pend_v = 1'b0; last_b = 8'h00;
        mpos2 = 0; pend2_v = 1'b0; last_b2 = 8'h00;
        fifo_empty = 1'b1; fifo_empty2 = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, fv0, n;
        #1;
        do_reset();
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Frame 0x01..0x0A with ack tied high.
        frame_ack = 1'b1;
        rd0 = rd_cnt; fv0 = fv_cnt;
        for (int i = 1; i <= F; i++) push(8'(i));
        wait_valid("frame1_valid", 60);
        repeat (4) tick();
        check("frame1_rd_pulses", 32'(rd_cnt - rd0), 10);
        check("frame1_valid_cycles", 32'(fv_cnt - fv0), 1);
        check("frame1_loads_done", 32'(expq.size()), 0);

        // FIFO runs dry after five bytes.
        rd0 = rd_cnt;
        for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
        repeat (25) tick();
        check("starve_rd_count", 32'(rd_cnt - rd0), 5);
        check("starve_no_valid", 32'(frame_valid), 0);
        for (int i = 5; i < F; i++) push(8'hA0 + 8'(i));
        n = 0;
        while (load_en !== 8'h20 && n < 20) begin tick(); n++; end
        check("refill_load20", 32'(load_en), 32'h20);
        check("refill_byte6", 32'(byte_data), 32'hA5);
        wait_valid("starve_valid", 40);
        repeat (3) tick();

        // Ack withheld with a second frame queued.
        frame_ack = 1'b0;
        for (int i = 0; i < 2 * F; i++) push(8'($urandom));
        wait_valid("hold_first_valid", 60);
        rd0 = rd_cnt;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("hold_valid", 32'(frame_valid), 1);
        end
        check("hold_no_rd", 32'(rd_cnt - rd0), 0);
        frame_ack = 1'b1;
        tick();
        check("ack_clears_valid", 32'(frame_valid), 0);
        wait_valid("second_frame_valid", 60);
        check("second_frame_rd", 32'(rd_cnt - rd0), 10);
        repeat (3) tick();

        // Checksum frames: correct trailer, then a corrupted one.
        for (int i = 1; i <= P; i++) push(8'(i * 8'h11));
        push(8'h88); push(8'h5A);
        wait_valid("chk_good_valid", 60);
        check("chk_good_err", 32'(frame_err), 0);
        repeat (3) tick();
        for (int i = 1; i <= P; i++) push(8'(i * 8'h11));
        push(8'h89); push(8'h5A);
        wait_valid("chk_bad_valid", 60);
`ifdef FRAME_CHKSUM_EN
        check("chk_bad_err", 32'(frame_err), 1);
`else
        check("chk_bad_err", 32'(frame_err), 0);
`endif
        repeat (3) tick();

        // Random frames, random gaps, random ack.
        frame_ack = 1'b0;
        for (int f = 0; f < 6; f++)
            for (int i = 0; i < F; i++) begin
                push(8'($urandom));
                repeat ($urandom_range(0, 3)) begin tick(); frame_ack = 1'($urandom_range(0, 1)); end
            end
        n = 0;
        while ((fpend > 0 || q.size() > 0 || mpos != 0 || frame_valid) && n < 400) begin
            tick(); frame_ack = 1'($urandom_range(0, 1)); n++;
        end
        check("random_drain", 32'(n < 400), 1);
        frame_ack = 1'b1;
        repeat (3) tick();

        // Reset during a capture cycle, then a clean frame.
        for (int i = 0; i < F; i++) push(8'h30 + 8'(i));
        n = 0;
        while (!(fifo_rd_en && mpos >= 3) && n < 40) begin tick(); n++; end
        check("midframe_reached", 32'(n < 40), 1);
        @(posedge clk);
        #2;
        do_reset();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < F; i++) push(8'h50 + 8'(i));
        wait_valid("post_reset_valid", 60);
        check("post_reset_loads", 32'(expq.size()), 0);
        repeat (3) tick();

        // POS_ARRAY == FRAME_BYTES instance.
        rd0 = rd2_cnt;
        for (int i = 0; i < F2; i++) push2(8'hC0 + 8'(i));
        repeat (30) tick();
        check("pf_rd_pulses", 32'(rd2_cnt - rd0), 4);
        check("pf_loads", 32'(ld2_cnt), 4);
        check("pf_valid_cycles", 32'(fv2_cnt), 1);
        check("pf_valid_after_load4", 32'(ld2_at_valid), 4);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/fifo_to_reg_ctrl.md
FIFO_TO_REG_CTRL -- requirements
Module: fifo_to_reg_ctrl

Interface
REQ-001 Parameter POS_ARRAY, default 8: number of kept payload bytes, one byte register per position.
REQ-002 Parameter FRAME_BYTES, default 10: bytes per UART frame read from the FIFO; FRAME_BYTES-POS_ARRAY trailing bytes are discarded.
REQ-003 Parameter BYTE_OUT, default 8: byte width.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  system clock; all state on rising edge.
REQ-006 sys_rst_l  in  1  asynchronous, active-high reset.
REQ-007 fifo_empty  in  1  FIFO has no data.
REQ-008 fifo_rd_en  out  1  one-cycle FIFO read request.
REQ-009 fifo_dout  in  BYTE_OUT  FIFO read data, valid the cycle after fifo_rd_en.
REQ-010 byte_data  out  BYTE_OUT  registered byte broadcast to all byte registers.
REQ-011 load_en  out  POS_ARRAY  one-hot load strobe, bit i loads register i.
REQ-012 frame_valid  out  1  all POS_ARRAY bytes loaded and trailer consumed.
REQ-013 frame_ack  in  1  consumer has taken the frame.
REQ-014 frame_err  out  1  checksum mismatch (FRAME_CHKSUM_EN only; tied 0 otherwise).

Function
REQ-015 FSM states: IDLE, READ, CAPTURE, DISCARD, DONE.
REQ-016 IDLE: byte counter = 0; if !fifo_empty, assert fifo_rd_en for one cycle and go to READ.
REQ-017 READ: wait the one-cycle FIFO latency; go to CAPTURE when cnt < POS_ARRAY, else DISCARD.
REQ-018 CAPTURE: byte_data <= fifo_dout, load_en <= one-hot(cnt) for exactly one cycle, cnt increments.
REQ-019 DISCARD: fifo_dout is dropped, load_en stays 0, cnt increments.
REQ-020 After CAPTURE/DISCARD: if cnt == FRAME_BYTES go to DONE; else if !fifo_empty issue fifo_rd_en and go to READ; else wait, without a timeout, with the byte position held.
REQ-021 Throughput: at most one byte per 2 cycles; fifo_rd_en is never asserted while fifo_empty=1.
REQ-022 DONE: frame_valid=1, held until frame_ack is sampled high, then clear frame_valid and go to IDLE the next cycle; no FIFO reads occur in DONE.
REQ-023 frame_ack outside DONE is ignored.
REQ-024 load_en is all zero except the single CAPTURE cycle; never more than one bit set.
REQ-025 byte_data holds its last value between captures.
REQ-026 Counter width is clog2(FRAME_BYTES+1); it wraps to 0 only through IDLE.
REQ-027 FRAME_BYTES == POS_ARRAY is legal: DISCARD is never entered.

Reset
REQ-028 On sys_rst_l=1, asynchronously: state=IDLE, cnt=0, fifo_rd_en=0, load_en=0, byte_data=0, frame_valid=0, frame_err=0.
REQ-029 A reset mid-frame abandons the partial frame; any FIFO read in flight is lost and is not replayed.

Configuration
REQ-030 Macro FRAME_CHKSUM_EN defined: accumulate the XOR of the POS_ARRAY captured bytes; compare it with the first discarded byte; on mismatch set frame_err together with frame_valid, and clear it with frame_valid.
REQ-031 FRAME_CHKSUM_EN undefined: no accumulator logic; frame_err is constant 0.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, default POS_ARRAY/FRAME_BYTES/BYTE_OUT constants, and the counter-width function.
REQ-033 Optional sub-module frame_xor_chk SHALL contain the checksum accumulator, instantiated only under FRAME_CHKSUM_EN; otherwise the block is flat.

Verification
REQ-034 Reset asserted mid-CAPTURE -> all outputs 0 immediately, state IDLE; next frame is captured from position 0.
REQ-035 FIFO preloaded with 0x01..0x0A, frame_ack tied 1 -> load_en walks 0x01..0x80 with byte_data 0x01..0x08; 10 rd_en pulses; frame_valid one cycle.
REQ-036 FIFO empties after byte 5 for 20 cycles -> no rd_en while empty; the sixth byte loads with load_en=0x20 after refill.
REQ-037 frame_ack held 0 for 50 cycles with a second frame queued -> frame_valid stays 1 and no rd_en; the second frame starts after the ack.
REQ-038 FRAME_CHKSUM_EN, payload 0x11..0x88 with correct XOR byte -> frame_err=0; with a corrupted XOR byte -> frame_err=1 together with frame_valid.
REQ-039 POS_ARRAY=FRAME_BYTES=4 -> exactly 4 rd_en, DISCARD never visited, frame_valid after the fourth load.
